// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Drives the select lines of a downstream 4:1 mux through inputs 0..3.
// At each address it waits SETTLE_CYCLES cycles and then samples mux_out.
// The four samples form the captured word, and a one-cycle done pulse marks
// the end of the scan.
// Handshake: start is accepted only in IDLE when abort is low. busy is high
// from the acceptance edge until the last sample is taken. done is high for
// exactly one cycle, and captured is valid in that cycle. captured holds its
// value until the next start is accepted. abort cancels a scan in SETTLE and
// has no effect in any other state.
// Optional feature: define MUXSEQ_PARITY_EN to add a registered parity
// output, which is the XOR of captured.

module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_out,
  output logic       address0,
  output logic       address1,
  output logic       busy,
  output logic       done,
  output logic [3:0] captured
`ifdef MUXSEQ_PARITY_EN
  ,
  output logic       parity
`endif
);

  // The settle counter is 4 bits wide, so only 1..15 can be represented.
  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("mux_scan_sequencer: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LP_RELOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_sel;
  logic [3:0] r_cnt;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_captured;

  logic       w_accept;
  logic       w_sample;
  logic [3:0] w_sample_word;

  // Abort takes priority over start in IDLE.
  // Abort also takes priority over the pending sample in SETTLE.
  assign w_accept = (r_state == ST_IDLE) && start && !abort;
  assign w_sample = (r_state == ST_SETTLE) && !abort && (r_cnt == 4'd1);

  // Build the captured word with the current select bit replaced by mux_out.
  always_comb begin
    w_sample_word        = r_captured;
    w_sample_word[r_sel] = mux_out;
  end

  // Scan FSM. The select, counter, busy, done and captured registers
  // are all updated in this one block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= 2'd0;
      r_cnt      <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_captured <= 4'b0000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sel  <= 2'd0;
          r_busy <= 1'b0;
          if (w_accept) begin
            r_state    <= ST_SETTLE;
            r_cnt      <= LP_RELOAD;
            r_captured <= 4'b0000;
            r_busy     <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'd0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
          end else if (w_sample) begin
            r_captured <= w_sample_word;
            if (r_sel == 2'd3) begin
              r_state <= ST_DONE;
              r_cnt   <= 4'd0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_sel <= r_sel + 2'd1;
              r_cnt <= LP_RELOAD;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_sel   <= 2'd0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_sel   <= 2'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign address0 = r_sel[0];
  assign address1 = r_sel[1];
  assign busy     = r_busy;
  assign done     = r_done;
  assign captured = r_captured;

`ifdef MUXSEQ_PARITY_EN
  logic r_parity;

  // Parity tracks captured: it is cleared on start and updated on each sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= 1'b0;
    end else if (w_sample) begin
      r_parity <= ^w_sample_word;
    end
  end

  assign parity = r_parity;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer.
// Two instances are used: one with SETTLE_CYCLES=1 and one with
// SETTLE_CYCLES=3. Each instance drives a 4:1 mux model.

module tb_mux_scan_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic       start_s [2];
  logic       abort_s [2];
  logic       mux_s   [2];
  logic       a0_s    [2];
  logic       a1_s    [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic [3:0] cap_s   [2];
  logic [3:0] vec_s   [2];
`ifdef MUXSEQ_PARITY_EN
  logic       par_s   [2];
`endif

  // Downstream 4:1 mux models: vec bit i is input in_i.
  assign mux_s[0] = vec_s[0][{a1_s[0], a0_s[0]}];
  assign mux_s[1] = vec_s[1][{a1_s[1], a0_s[1]}];

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start_s[0]),
    .abort    (abort_s[0]),
    .mux_out  (mux_s[0]),
    .address0 (a0_s[0]),
    .address1 (a1_s[0]),
    .busy     (busy_s[0]),
    .done     (done_s[0]),
    .captured (cap_s[0])
`ifdef MUXSEQ_PARITY_EN
    ,
    .parity   (par_s[0])
`endif
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(3)) u_dut_s3 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start_s[1]),
    .abort    (abort_s[1]),
    .mux_out  (mux_s[1]),
    .address0 (a0_s[1]),
    .address1 (a1_s[1]),
    .busy     (busy_s[1]),
    .done     (done_s[1]),
    .captured (cap_s[1])
`ifdef MUXSEQ_PARITY_EN
    ,
    .parity   (par_s[1])
`endif
  );

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int         exp_cyc_q[$];
  int         exp_dut_q[$];
  logic [3:0] last_cap [2];

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Idle expectations: select 0, not busy, no done, captured held.
  task automatic check_idle(input int d, input logic [3:0] cap_exp, input string name);
    check(name, {a1_s[d], a0_s[d], busy_s[d], done_s[d], cap_s[d]},
          {2'b00, 1'b0, 1'b0, cap_exp});
`ifdef MUXSEQ_PARITY_EN
    check({name, "_parity"}, par_s[d], ^cap_exp);
`endif
  endtask

  // Monitor: every done pulse pops one expected completion.
  logic [3:0] mon_cap;
  int         mon_cyc;
  int         mon_dut;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done_s[d] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done dut=%0d actual=pulse required=none at cycle %0d", d, cyc);
        end else begin
          mon_cap = exp_q.pop_front();
          mon_cyc = exp_cyc_q.pop_front();
          mon_dut = exp_dut_q.pop_front();
          check("done_dut", d, mon_dut);
          check("done_cycle", cyc, mon_cyc);
          check("done_captured", cap_s[d], mon_cap);
          check("done_sel_busy", {a1_s[d], a0_s[d], busy_s[d]}, {2'b11, 1'b0});
`ifdef MUXSEQ_PARITY_EN
          check("done_parity", par_s[d], ^mon_cap);
`endif
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Runs one scan on DUT d with mux inputs vec.
  // abort_k (1..4S+1) raises abort during that cycle of the scan; 0 means no abort.
  // st_a and st_b raise stray start requests during those cycles of the scan.
  task automatic run_scan(input int d, input logic [3:0] vec, input int abort_k,
                          input int st_a, input int st_b);
    int         s;
    int         m;
    logic [1:0] es;
    logic       eb;
    logic [3:0] exp_cap;
    s = settle_of(d);
    @(negedge clk);
    vec_s[d]   = vec;
    start_s[d] = 1'b1;
    abort_s[d] = 1'b0;
    if (abort_k < 1 || abort_k > 4 * s) begin
      exp_q.push_back(vec);
      exp_cyc_q.push_back(cyc + 4 * s + 1);
      exp_dut_q.push_back(d);
    end
    for (int k = 1; k <= 4 * s + 1; k++) begin
      @(negedge clk);
      es = (k <= 4 * s) ? 2'((k - 1) / s) : 2'd3;
      eb = (k <= 4 * s);
      check("scan_sel_busy", {a1_s[d], a0_s[d], busy_s[d]}, {es, eb});
      start_s[d] = (k == st_a) || (k == st_b);
      abort_s[d] = (k == abort_k);
      if (k == abort_k && k <= 4 * s) begin
        m       = (k - 1) / s;
        exp_cap = vec & 4'((1 << m) - 1);
        @(negedge clk);
        start_s[d] = 1'b0;
        abort_s[d] = 1'b0;
        check_idle(d, exp_cap, "abort_idle");
        last_cap[d] = exp_cap;
        return;
      end
    end
    start_s[d] = 1'b0;
    abort_s[d] = 1'b0;
    @(negedge clk);
    check_idle(d, vec, "post_done_hold");
    last_cap[d] = vec;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d;
    int s;
    int ak;
    int sa;
    int sb;
    for (int i = 0; i < 2; i++) begin
      start_s[i]  = 1'b0;
      abort_s[i]  = 1'b0;
      vec_s[i]    = 4'b0000;
      last_cap[i] = 4'b0000;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle with no start.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_idle(0, 4'b0000, "reset_idle_s1");
      check_idle(1, 4'b0000, "reset_idle_s3");
    end

    // Directed scans.
    run_scan(0, 4'b1101, 0, 0, 0);
    run_scan(1, 4'b0110, 0, 0, 0);
    run_scan(1, 4'b1001, 0, 2, 5);
    run_scan(0, 4'b1111, 3, 0, 0);

    // Start together with abort in IDLE: abort wins.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start_s[i] = 1'b1;
      abort_s[i] = 1'b1;
      @(negedge clk);
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      check_idle(i, last_cap[i], "start_abort_idle");
    end

    // Asynchronous reset while select = 1 on the SETTLE_CYCLES=3 instance.
    @(negedge clk);
    vec_s[1]   = 4'b1111;
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_sel", {a1_s[1], a0_s[1], busy_s[1]}, {2'b01, 1'b1});
    #2;
    reset_n = 1'b0;
    #1;
    check_idle(0, 4'b0000, "async_reset_s1");
    check_idle(1, 4'b0000, "async_reset_s3");
    last_cap[0] = 4'b0000;
    last_cap[1] = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_scan(1, 4'b1010, 0, 0, 0);

    // Randomized scans.
    repeat (24) begin
      d  = $urandom_range(0, 1);
      s  = settle_of(d);
      ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4 * s + 1) : 0;
      sa = $urandom_range(0, 4 * s);
      sb = $urandom_range(0, 4 * s);
      run_scan(d, 4'($urandom_range(0, 15)), ak, sa, sb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
